// File: rtl/seven_seg_capture.sv
// seven_seg_capture: watches a multiplexed 4-digit seven-segment bus and rebuilds the
// hex value shown, publishing a frame once every position has been captured.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [15:0] digits,
    output logic [3:0]  blank,
    output logic        frame_valid,
    output logic        err
);
    typedef enum logic {WAIT, LOCKED} state_t;
    state_t      state_q, state_d;
    logic [6:0]  seg_q;
    logic [3:0]  an_q;
    logic [10:0] prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [3:0]  sblank_q, sblank_d, seen_q, seen_d;
    logic        changed, onehot, accept, complete;
    logic [4:0]  dec;
    logic [1:0]  pos;

    // dec[4] flags a decodable pattern; all-dark decodes as value 0
    always_comb begin
        case (seg_q)
            7'h7e, 7'h00: dec = 5'h10;
            7'h30: dec = 5'h11;
            7'h6d: dec = 5'h12;
            7'h79: dec = 5'h13;
            7'h33: dec = 5'h14;
            7'h5b: dec = 5'h15;
            7'h5f: dec = 5'h16;
            7'h70: dec = 5'h17;
            7'h7f: dec = 5'h18;
            7'h7b: dec = 5'h19;
            7'h77: dec = 5'h1a;
            7'h1f: dec = 5'h1b;
            7'h4e: dec = 5'h1c;
            7'h3d: dec = 5'h1d;
            7'h4f: dec = 5'h1e;
            7'h47: dec = 5'h1f;
            default: dec = 5'h00;
        endcase
    end

    always_comb begin
        changed  = {seg_q, an_q} != prev_q;
        onehot   = (an_q != 4'd0) && ((an_q & (an_q - 4'd1)) == 4'd0);
        pos      = an_q[3] ? 2'd3 : an_q[2] ? 2'd2 : an_q[1] ? 2'd1 : 2'd0;
        cnt_d    = (changed || !onehot) ? 8'd0 : cnt_q + {7'd0, cnt_q != 8'hFF};
        // a change edge may itself accept when only one stable sample is required
        accept   = onehot && (changed || state_q == WAIT) && cnt_d == 8'(STABLE_CYCLES - 1);
        state_d  = accept ? LOCKED : changed ? WAIT : state_q;
        complete = seen_q == 4'hF;
        seen_d   = complete ? 4'h0 : seen_q;
        shadow_d = shadow_q;
        sblank_d = sblank_q;
        if (accept) begin
            seen_d[pos] = dec[4];
            if (dec[4]) begin
                shadow_d[{pos, 2'b00} +: 4] = dec[3:0];
                sblank_d[pos] = seg_q == 7'h00;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seg_q       <= '0;
            an_q        <= '0;
            prev_q      <= '0;
            cnt_q       <= '0;
            state_q     <= WAIT;
            shadow_q    <= '0;
            sblank_q    <= '0;
            seen_q      <= '0;
            digits      <= '0;
            blank       <= 4'hF;
            frame_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            seg_q       <= seg;
            an_q        <= an;
            prev_q      <= {seg_q, an_q};
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            shadow_q    <= shadow_d;
            sblank_q    <= sblank_d;
            seen_q      <= seen_d;
            frame_valid <= complete;
            err         <= accept && !dec[4];
            if (complete) begin
                digits <= shadow_q;
                blank  <= sblank_q;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: two instances (4-sample and 1-sample filters) share one bus and are
// compared against a hold-level model of the display capture.
module tb_seven_seg_capture;
    logic        clk = 1'b0, reset = 1'b1;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] dig[2];
    logic [3:0]  blk[2];
    logic        fv[2], er[2];

    seven_seg_capture #(.STABLE_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .seg(seg), .an(an),
        .digits(dig[0]), .blank(blk[0]), .frame_valid(fv[0]), .err(er[0]));
    seven_seg_capture #(.STABLE_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .seg(seg), .an(an),
        .digits(dig[1]), .blank(blk[1]), .frame_valid(fv[1]), .err(er[1]));

    always #5 clk = ~clk;

    int cyc = 0, passed = 0, total = 0, e0 = 0;
    int fcnt[2] = '{0, 0}, ecnt[2] = '{0, 0}, last_fv[2] = '{0, 0}, last_er[2] = '{0, 0};
    logic [6:0] enc[16] = '{7'h7e, 7'h30, 7'h6d, 7'h79, 7'h33, 7'h5b, 7'h5f, 7'h70,
                            7'h7f, 7'h7b, 7'h77, 7'h1f, 7'h4e, 7'h3d, 7'h4f, 7'h47};
    logic [3:0]  m_sh[2][4];
    logic [3:0]  m_sb[2], m_seen[2], m_blk[2];
    logic [15:0] m_dig[2];
    int          m_frames[2] = '{0, 0}, m_errs[2] = '{0, 0};

    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (fv[k] === 1'b1) begin fcnt[k]++; last_fv[k] = cyc; end
            if (er[k] === 1'b1) begin ecnt[k]++; last_er[k] = cyc; end
        end
    end

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) m_sh[k][p] = 4'h0;
            m_sb[k] = 4'h0; m_seen[k] = 4'h0; m_dig[k] = 16'h0; m_blk[k] = 4'hF;
        end
    endtask

    task automatic m_publish(int k);
        m_dig[k] = {m_sh[k][3], m_sh[k][2], m_sh[k][1], m_sh[k][0]};
        m_blk[k] = m_sb[k];
        m_seen[k] = 4'h0;
        m_frames[k]++;
    endtask

    task automatic m_accept(int k, int p, logic [6:0] s);
        int v;
        v = -1;
        if (m_seen[k] == 4'hF) m_publish(k);
        for (int i = 0; i < 16; i++) if (enc[i] == s) v = i;
        if (s == 7'h00) v = 0;
        if (v < 0) begin
            m_errs[k]++;
            m_seen[k][p] = 1'b0;
        end else begin
            m_sh[k][p] = 4'(v);
            m_sb[k][p] = (s == 7'h00);
            m_seen[k][p] = 1'b1;
        end
    endtask

    task automatic hold(logic [3:0] a, logic [6:0] s, int len);
        seg = s; an = a; e0 = cyc + 1;
        repeat (len) @(posedge clk);
        #1;
        if ($countones(a) == 1)
            for (int k = 0; k < 2; k++) if (len >= (k == 0 ? 4 : 1)) m_accept(k, $clog2(a), s);
    endtask

    task automatic flush();
        seg = '0; an = '0;
        repeat (6) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) if (m_seen[k] == 4'hF) m_publish(k);
    endtask

    task automatic do_reset();
        seg = '0; an = '0; reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            seg = 7'($urandom); an = 4'($urandom);
            @(posedge clk);
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            total++; if (dig[k] !== 16'h0) $display("FAIL reset_digits[%0d]: got %h expected 0000", k, dig[k]); else passed++;
            total++; if (blk[k] !== 4'hF) $display("FAIL reset_blank[%0d]: got %h expected f", k, blk[k]); else passed++;
            total++; if (fv[k] !== 1'b0) $display("FAIL reset_fv[%0d]: got %b expected 0", k, fv[k]); else passed++;
            total++; if (er[k] !== 1'b0) $display("FAIL reset_err[%0d]: got %b expected 0", k, er[k]); else passed++;
        end
        do_reset();
    endtask

    task automatic test_nominal();
        int f0[2];
        do_reset();
        f0 = fcnt;
        hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h6d, 8); hold(4'b0100, 7'h7b, 8); hold(4'b1000, 7'h5b, 8);
        flush();
        total++; if (dig[0] !== 16'h5921) $display("FAIL nominal_digits: got %h expected 5921", dig[0]); else passed++;
        total++; if (blk[0] !== 4'h0) $display("FAIL nominal_blank: got %h expected 0", blk[0]); else passed++;
        total++; if (last_fv[0] - e0 != 5) $display("FAIL nominal_latency: got %0d expected 5", last_fv[0] - e0); else passed++;
        for (int k = 0; k < 2; k++) begin
            total++; if (fcnt[k] - f0[k] != 1) $display("FAIL nominal_frames[%0d]: got %0d expected 1", k, fcnt[k] - f0[k]); else passed++;
            total++; if (ecnt[k] != m_errs[k]) $display("FAIL nominal_err[%0d]: got %0d expected %0d", k, ecnt[k], m_errs[k]); else passed++;
            total++; if (dig[k] !== m_dig[k]) $display("FAIL nominal_model[%0d]: got %h expected %h", k, dig[k], m_dig[k]); else passed++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        hold(4'b0001, 7'h7f, 2); hold(4'b0001, 7'h30, 8);
        hold(4'b0010, 7'h6d, 8); hold(4'b0100, 7'h7b, 8); hold(4'b1000, 7'h5b, 8);
        flush();
        total++; if (dig[0][3:0] !== 4'h1) $display("FAIL glitch_digit0: got %h expected 1", dig[0][3:0]); else passed++;
        for (int k = 0; k < 2; k++) begin
            total++; if (dig[k] !== m_dig[k]) $display("FAIL glitch_digits[%0d]: got %h expected %h", k, dig[k], m_dig[k]); else passed++;
            total++; if (fcnt[k] != m_frames[k]) $display("FAIL glitch_frames[%0d]: got %0d expected %0d", k, fcnt[k], m_frames[k]); else passed++;
        end
    endtask

    task automatic test_invalid();
        int f0, x0;
        do_reset();
        hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h6d, 8); hold(4'b1000, 7'h5b, 8);
        f0 = fcnt[0]; x0 = ecnt[0];
        hold(4'b0100, 7'h01, 8);
        total++; if (ecnt[0] - x0 != 1) $display("FAIL invalid_errcount: got %0d expected 1", ecnt[0] - x0); else passed++;
        total++; if (last_er[0] - e0 != 4) $display("FAIL invalid_errtime: got %0d expected 4", last_er[0] - e0); else passed++;
        total++; if (fcnt[0] != f0) $display("FAIL invalid_noframe: got %0d expected %0d", fcnt[0], f0); else passed++;
        hold(4'b0100, 7'h7b, 8);
        flush();
        total++; if (dig[0] !== 16'h5921) $display("FAIL invalid_recover: got %h expected 5921", dig[0]); else passed++;
        for (int k = 0; k < 2; k++) begin
            total++; if (ecnt[k] != m_errs[k]) $display("FAIL invalid_err[%0d]: got %0d expected %0d", k, ecnt[k], m_errs[k]); else passed++;
            total++; if (fcnt[k] != m_frames[k]) $display("FAIL invalid_frames[%0d]: got %0d expected %0d", k, fcnt[k], m_frames[k]); else passed++;
        end
    endtask

    task automatic test_blank_hold();
        int f0;
        do_reset();
        f0 = fcnt[0];
        hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h6d, 8); hold(4'b0100, 7'h7b, 8); hold(4'b1000, 7'h00, 50);
        total++; if (blk[0] !== 4'h8) $display("FAIL blank_mask: got %h expected 8", blk[0]); else passed++;
        total++; if (dig[0][15:12] !== 4'h0) $display("FAIL blank_digit3: got %h expected 0", dig[0][15:12]); else passed++;
        total++; if (fcnt[0] - f0 != 1) $display("FAIL blank_frames: got %0d expected 1", fcnt[0] - f0); else passed++;
        hold(4'b0001, 7'h7e, 8); hold(4'b0010, 7'h30, 8); hold(4'b0100, 7'h6d, 8);
        flush();
        for (int k = 0; k < 2; k++) begin
            total++; if (fcnt[k] != m_frames[k]) $display("FAIL blank_norepeat[%0d]: got %0d expected %0d", k, fcnt[k], m_frames[k]); else passed++;
            total++; if (blk[k] !== m_blk[k]) $display("FAIL blank_model[%0d]: got %h expected %h", k, blk[k], m_blk[k]); else passed++;
        end
    endtask

    task automatic test_reset_midframe();
        int f0[2];
        do_reset();
        f0 = fcnt;
        hold(4'b0001, 7'h30, 8); hold(4'b0010, 7'h6d, 8); hold(4'b0100, 7'h7b, 8);
        do_reset();
        hold(4'b1000, 7'h5b, 8);
        flush();
        for (int k = 0; k < 2; k++) begin
            total++; if (fcnt[k] != f0[k]) $display("FAIL midreset_frames[%0d]: got %0d expected %0d", k, fcnt[k], f0[k]); else passed++;
            total++; if (dig[k] !== 16'h0) $display("FAIL midreset_digits[%0d]: got %h expected 0000", k, dig[k]); else passed++;
            total++; if (blk[k] !== 4'hF) $display("FAIL midreset_blank[%0d]: got %h expected f", k, blk[k]); else passed++;
        end
    endtask

    task automatic test_latency_s1();
        do_reset();
        hold(4'b0001, 7'h7e, 2); hold(4'b0010, 7'h30, 2); hold(4'b0100, 7'h6d, 2); hold(4'b1000, 7'h79, 2);
        flush();
        total++; if (last_fv[1] - e0 != 2) $display("FAIL s1_latency: got %0d expected 2", last_fv[1] - e0); else passed++;
        for (int k = 0; k < 2; k++) begin
            total++; if (dig[k] !== m_dig[k]) $display("FAIL s1_digits[%0d]: got %h expected %h", k, dig[k], m_dig[k]); else passed++;
            total++; if (fcnt[k] != m_frames[k]) $display("FAIL s1_frames[%0d]: got %0d expected %0d", k, fcnt[k], m_frames[k]); else passed++;
        end
    endtask

    task automatic test_random();
        logic [3:0] a, pa;
        logic [6:0] s, ps;
        do_reset();
        for (int r = 0; r < 6; r++) begin
            pa = '0; ps = '0;
            for (int h = 0; h < 40; h++) begin
                case ($urandom_range(0, 9))
                    7:       a = 4'h0;
                    8, 9:    a = 4'($urandom);
                    default: a = 4'b0001 << $urandom_range(0, 3);
                endcase
                case ($urandom_range(0, 9))
                    7:       s = 7'h00;
                    8, 9:    s = 7'($urandom);
                    default: s = enc[$urandom_range(0, 15)];
                endcase
                if ({a, s} == {pa, ps}) s = s ^ 7'h40;
                hold(a, s, $urandom_range(1, 8));
                pa = a; ps = s;
            end
            flush();
            for (int k = 0; k < 2; k++) begin
                total++; if (dig[k] !== m_dig[k]) $display("FAIL rand_digits[%0d] r%0d: got %h expected %h", k, r, dig[k], m_dig[k]); else passed++;
                total++; if (blk[k] !== m_blk[k]) $display("FAIL rand_blank[%0d] r%0d: got %h expected %h", k, r, blk[k], m_blk[k]); else passed++;
                total++; if (fcnt[k] != m_frames[k]) $display("FAIL rand_frames[%0d] r%0d: got %0d expected %0d", k, r, fcnt[k], m_frames[k]); else passed++;
                total++; if (ecnt[k] != m_errs[k]) $display("FAIL rand_err[%0d] r%0d: got %0d expected %0d", k, r, ecnt[k], m_errs[k]); else passed++;
            end
        end
    endtask

    initial begin
        m_reset();
        test_reset();
        test_nominal();
        test_glitch();
        test_invalid();
        test_blank_hold();
        test_reset_midframe();
        test_latency_s1();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
